// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle RV64 data-memory target with lane-masked stores.
// DMEM_ERR_EN: report misaligned accesses as errors instead of force-aligning them.
module dmem_responder #(
   parameter int XLEN    = 64,
   parameter int DEPTH   = 512,
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(LATENCY + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  mem [DEPTH];

   logic              latWe;
   logic              latUns;
   logic [ADDR_W-1:0] latAddr;
   logic [1:0]        latSize;
   logic [XLEN-1:0]   latWdata;

   logic              accept;
   logic              enterResp;
   logic              opWe;
   logic              opUns;
   logic [ADDR_W-1:0] opAddr;
   logic [1:0]        opSize;
   logic [XLEN-1:0]   opWdata;

   logic [2:0]       rawLane;
   logic [2:0]       lane;
   logic [2:0]       alignMask;
   logic [7:0]       sizeMask;
   logic [7:0]       byteEn;
   logic             errOn;
   logic             sgn;
   logic [IDX_W-1:0] idx;
   logic [XLEN-1:0]  curWord;
   logic [XLEN-1:0]  shWord;
   logic [XLEN-1:0]  wShift;
   logic [XLEN-1:0]  loadVal;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;
   assign enterResp = (accept && LATENCY == 1) ||
                      (state == WAIT && cnt == '0);

   // With LATENCY=1 the commit edge is the accept edge, so use live inputs.
   assign opWe    = (state == IDLE) ? req_we       : latWe;
   assign opUns   = (state == IDLE) ? req_unsigned : latUns;
   assign opAddr  = (state == IDLE) ? req_addr     : latAddr;
   assign opSize  = (state == IDLE) ? req_size     : latSize;
   assign opWdata = (state == IDLE) ? req_wdata    : latWdata;

   assign rawLane = opAddr[2:0];
   assign idx     = opAddr[IDX_W+2:3];
   assign sgn     = !opUns;

   always_comb begin
      alignMask = 3'b000;
      sizeMask  = 8'h01;
      unique case (opSize)
         2'd0: begin alignMask = 3'b000; sizeMask = 8'h01; end
         2'd1: begin alignMask = 3'b001; sizeMask = 8'h03; end
         2'd2: begin alignMask = 3'b011; sizeMask = 8'h0F; end
         2'd3: begin alignMask = 3'b111; sizeMask = 8'hFF; end
      endcase
   end

`ifdef DMEM_ERR_EN
   assign errOn = (rawLane & alignMask) != 3'b000;
   assign lane  = rawLane;
`else
   assign errOn = 1'b0;
   assign lane  = rawLane & ~alignMask;
`endif

   assign byteEn  = sizeMask << lane;
   assign curWord = mem[idx];
   assign shWord  = curWord >> {lane, 3'b000};
   assign wShift  = opWdata << {lane, 3'b000};

   always_comb begin
      loadVal = shWord;
      unique case (opSize)
         2'd0: loadVal = {{(XLEN-8){sgn & shWord[7]}}, shWord[7:0]};
         2'd1: loadVal = {{(XLEN-16){sgn & shWord[15]}}, shWord[15:0]};
         2'd2: loadVal = {{(XLEN-32){sgn & shWord[31]}}, shWord[31:0]};
         2'd3: loadVal = shWord;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  latWe    <= req_we;
                  latUns   <= req_unsigned;
                  latAddr  <= req_addr;
                  latSize  <= req_size;
                  latWdata <= req_wdata;
                  if (LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_W'(LATENCY - 2);
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) state <= RESP;
               else cnt <= cnt - 1'b1;
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (enterResp) begin
            rsp_err   <= errOn;
            rsp_rdata <= (opWe || errOn) ? '0 : loadVal;
         end
      end
   end

   // Array is not reset; a reset on the commit edge blocks the write.
   always_ff @(posedge clk) begin
      if (!rst && enterResp && opWe && !errOn) begin
         for (int b = 0; b < 8; b++) begin
            if (byteEn[b]) mem[idx][8*b +: 8] <= wShift[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed load/store traffic checked
// against a byte-addressed reference memory.
module tb_dmem_responder;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [11:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   int nChecks = 0;
   int nErrors = 0;
   logic [7:0] mb [4096];

   dmem_responder #(
      .XLEN(64), .DEPTH(512), .ADDR_W(12), .LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model(input bit we, input logic [11:0] a0,
                        input logic [1:0] sz, input bit u,
                        input logic [63:0] wd,
                        output logic [63:0] rd, output bit er);
      int nb;
      int a;
      nb = 1 << sz;
      a  = int'(a0);
      rd = '0;
      er = 1'b0;
      if (a % nb != 0) begin
`ifdef DMEM_ERR_EN
         er = 1'b1;
         return;
`else
         a = a - (a % nb);
`endif
      end
      if (we) begin
         for (int i = 0; i < nb; i++) mb[a+i] = wd[8*i +: 8];
      end else begin
         for (int i = nb - 1; i >= 0; i--) rd = (rd << 8) | 64'(mb[a+i]);
         if (!u && nb < 8 && rd[8*nb-1]) rd = rd | (~64'd0 << (8*nb));
      end
   endtask

   task automatic txn(input bit we, input logic [11:0] a,
                      input logic [1:0] sz, input bit u,
                      input logic [63:0] wd, input int hold,
                      output logic [63:0] got);
      logic [63:0] expD;
      bit expE;
      int n;
      model(we, a, sz, u, wd, expD, expE);
      check("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_we = we; req_addr = a; req_size = sz;
      req_unsigned = u; req_wdata = wd;
      @(posedge clk); #1;
      req_valid    = 1'($urandom);
      req_we       = 1'($urandom);
      req_addr     = 12'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_wdata    = {$urandom, $urandom};
      n = 1;
      while (!rsp_valid && n < LAT + 8) begin
         @(posedge clk); #1;
         n++;
      end
      check("rsp_latency", 64'(n), 64'(LAT));
      got = rsp_rdata;
      if (!rsp_valid) begin
         req_valid = 1'b0;
         return;
      end
      check("rsp_rdata", rsp_rdata, expD);
      check("rsp_err", 64'(rsp_err), 64'(expE));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 64'(rsp_valid), 64'd1);
         check("hold_rdata", rsp_rdata, expD);
         check("hold_req_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      check("post_rsp_valid", 64'(rsp_valid), 64'd0);
      check("post_req_ready", 64'(req_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] r;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_rdata", rsp_rdata, 64'd0);
      check("rst_rsp_err", 64'(rsp_err), 64'd0);

      for (int w = 0; w < 32; w++)
         txn(1'b1, 12'(w * 8), 2'd3, 1'b0, {$urandom, $urandom}, 0, r);

      txn(1'b1, 12'h010, 2'd3, 1'b0, 64'h0123456789ABCDEF, 0, r);
      check("sd_rdata_zero", r, 64'd0);
      txn(1'b0, 12'h010, 2'd3, 1'b0, 64'd0, 0, r);
      check("ld_10", r, 64'h0123456789ABCDEF);

      txn(1'b1, 12'h013, 2'd0, 1'b0, 64'h80, 0, r);
      txn(1'b0, 12'h013, 2'd0, 1'b0, 64'd0, 0, r);
      check("lb_13", r, 64'hFFFFFFFFFFFFFF80);
      txn(1'b0, 12'h013, 2'd0, 1'b1, 64'd0, 0, r);
      check("lbu_13", r, 64'h0000000000000080);
      txn(1'b0, 12'h010, 2'd3, 1'b0, 64'd0, 5, r);
      check("ld_10_after_sb", r, 64'h0123456780ABCDEF);

      txn(1'b1, 12'h016, 2'd2, 1'b0, 64'hDEADBEEF, 0, r);
      txn(1'b0, 12'h010, 2'd3, 1'b1, 64'd0, 0, r);
`ifdef DMEM_ERR_EN
      check("ld_10_after_bad_sw", r, 64'h0123456780ABCDEF);
`else
      check("ld_10_after_sw", r, 64'hDEADBEEF80ABCDEF);
`endif

      req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h020;
      req_size = 2'd3; req_unsigned = 1'b0; req_wdata = 64'hFFFF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("midrst_req_ready", 64'(req_ready), 64'd1);
      repeat (3) @(posedge clk);
      #1 check("midrst_still_idle", 64'(rsp_valid), 64'd0);
      txn(1'b0, 12'h020, 2'd3, 1'b0, 64'd0, 0, r);

      txn(1'b1, 12'hFF8, 2'd3, 1'b0, 64'h8877665544332211, 0, r);
      txn(1'b0, 12'hFFF, 2'd0, 1'b0, 64'd0, 0, r);
      check("lb_fff", r, 64'hFFFFFFFFFFFFFF88);
      txn(1'b0, 12'hFFC, 2'd2, 1'b1, 64'd0, 1, r);
      check("lwu_ffc", r, 64'h0000000088776655);

      for (int k = 0; k < 300; k++)
         txn($urandom_range(0, 2) == 0, 12'($urandom_range(0, 255)),
             2'($urandom), 1'($urandom), {$urandom, $urandom},
             int'($urandom_range(0, 3)), r);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipelined RV64 core. It is the target side of the core's load/store request port. It accepts one request at a time over a valid/ready handshake and models a fixed multi-cycle access latency. It performs byte/half/word/double stores with lane masking, returns sign- or zero-extended load data, and holds the response until the core takes it. It sits beside risc_top and replaces the single-cycle data memory once the memory stage is made stall-aware.

Parameters:
XLEN, 64, data width in bits; fixed at 64 for this core.
DEPTH, 512, number of 64-bit words in the array; must be a power of 2.
ADDR_W, 12, width of the byte address.
LATENCY, 2, cycles from request accept to rsp_valid; must be at least 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  ADDR_W  byte address.
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = double.
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
req_wdata  input  XLEN  store data, LSB-aligned.
rsp_valid  output  1  response present.
rsp_ready  input  1  core accepts the response.
rsp_rdata  output  XLEN  extended load data; 0 for stores and errors.
rsp_err  output  1  misaligned access.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- FSM states: IDLE, WAIT, RESP. Reset puts the FSM in IDLE.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Array contents are not reset.
- req_ready is 1 only in IDLE, including the first cycle after reset is released.
- Accept: req_valid & req_ready at a rising edge latches we/addr/size/unsigned/wdata.
  - LATENCY=1: go directly to RESP.
  - Otherwise: go to WAIT with counter=LATENCY-2.
- WAIT: counter decrements each cycle; at counter==0 go to RESP.
- rsp_valid rises exactly LATENCY cycles after the accept edge.
- Commit: the array read and write happen on the edge entering RESP. Response data is registered and held stable for the whole of RESP.
- RESP: held until rsp_ready=1; then return to IDLE. There is no same-cycle turnaround, so the next request can be accepted no earlier than the cycle after the response handshake.
- Indexing:
  - word index = addr[log2(DEPTH)+2:3]; higher address bits are ignored (aliasing).
  - byte lane = addr[2:0]; data is little-endian.
- Store: only the bytes selected by size and lane are written, from wdata[8*n-1:0]. rsp_rdata=0.
- Load:
  - extract the selected bytes;
  - extend to 64 bits, using the sign bit unless unsigned;
  - the unsigned flag is ignored for a double load.
- Misaligned: lane is not a multiple of the access size in bytes (see Optional Feature).
- Reset mid-operation: the transaction is abandoned. A store still in WAIT is not written. A response in RESP is dropped.
- Inputs are sampled only on the accept edge; changes to them while busy have no effect.

Optional Feature:
DMEM_ERR_EN
- Defined:
  - a misaligned request skips the array write;
  - it returns rsp_err=1 and rsp_rdata=0;
  - timing is otherwise identical to a normal access.
- Undefined:
  - rsp_err is tied to 0;
  - the low address bits are masked to natural alignment (byte: none; half: [0]; word: [1:0]; double: [2:0]);
  - the access then proceeds normally.

Test Plan:
1. Hold rst=1 for 2 cycles, then release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 in the first cycle after release.
2. With LATENCY=2: sd 0x0123456789ABCDEF to 0x10, handshake, then ld 0x10 -> rsp_valid high exactly 2 cycles after the accept edge, rdata=0x0123456789ABCDEF, err=0.
3. sb wdata=0x80 to 0x13, then:
   - lb 0x13 -> 0xFFFFFFFFFFFFFF80;
   - lbu 0x13 -> 0x0000000000000080;
   - ld 0x10 -> 0x0123456780ABCDEF.
4. Response backpressure: hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid/rdata stable and req_ready=0 throughout. Raise rsp_ready -> req_ready=1 on the next cycle, with no accept in the handshake cycle.
5. With DMEM_ERR_EN: sw 0xDEADBEEF at 0x16 -> rsp_err=1, rdata=0; a following ld 0x10 returns 0x0123456780ABCDEF. Without the macro, the same sw writes lane 4 and ld 0x10 returns 0xDEADBEEF80ABCDEF.
6. Issue sd 0xFFFF to 0x20 and assert rst for 1 cycle on the edge after the accept edge -> FSM returns to IDLE, rsp_valid=0. A following ld 0x20 returns the prior contents, not 0xFFFF.
